spi_slave_fd: RTL and testbench
===============================

SPI_SLAVE_FD -- requirements
Module: spi_slave_fd

Interface
REQ-001 Parameter DATA_LEN, default 8, word length in bits (2..32).
REQ-002 Parameter CPOL, default 0, sck idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB shifted first on both mosi and miso, 0 = LSB first.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sck  input  1  SPI clock from master, asynchronous to clk.
REQ-008 ss  input  1  slave select, active-low, asynchronous to clk.
REQ-009 mosi  input  1  master-out data, asynchronous to clk.
REQ-010 miso  output  1  slave-out data.
REQ-011 tx_data  input  DATA_LEN  next word to transmit.
REQ-012 tx_load  input  1  write strobe for tx_data.
REQ-013 tx_ready  output  1  high when the TX holding buffer is empty.
REQ-014 rx_data  output  DATA_LEN  last complete received word.
REQ-015 rx_valid  output  1  one-clk pulse marking a new rx_data.
REQ-016 tx_underrun  output  1  one-clk pulse: word started with an empty TX buffer.
REQ-017 busy  output  1  high while ss is low (synchronised).

Function
REQ-018 sck, ss and mosi SHALL each pass through a 2-flop synchroniser before use; sck edges SHALL be detected on the synchronised signal.
REQ-019 Leading edge = rising when CPOL=0, falling when CPOL=1; sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
REQ-020 Operation requires sck high and low phases each ≥ 4 clk periods; behaviour outside that SHALL be undefined.
REQ-021 FSM states IDLE, LOAD, XFER; IDLE -> LOAD on synchronised ss falling; LOAD -> XFER after one clk; XFER -> IDLE on synchronised ss rising, from any bit position.
REQ-022 In LOAD and at each word boundary, the shift register SHALL load the TX buffer and set tx_ready=1; if the buffer is empty, it SHALL load all zeros and pulse tx_underrun.
REQ-023 tx_load while tx_ready=1 SHALL capture tx_data and clear tx_ready next clk; tx_load while tx_ready=0 SHALL be ignored.
REQ-024 tx_load coincident with a word-boundary consumption of an empty buffer SHALL fill the buffer for the following word, not the current one.
REQ-025 CPHA=0: first TX bit on miso before the first sck edge; CPHA=1: first TX bit on miso at the first shift edge.
REQ-026 Each sample edge SHALL shift synchronised mosi into the RX shift register and increment a bit counter modulo DATA_LEN.
REQ-027 When the counter wraps, rx_data SHALL update and rx_valid SHALL pulse for exactly one clk, within 4 clk of the physical sampling edge.
REQ-028 Frames of multiple words SHALL be supported without ss deassertion; each word boundary reloads TX (REQ-022).
REQ-029 ss rising mid-word SHALL discard the partial word: no rx_valid, counter to 0, rx_data unchanged; TX buffer contents retained.
REQ-030 miso SHALL drive 0 whenever the FSM is IDLE.

Reset
REQ-031 rst SHALL asynchronously force: FSM IDLE, counter 0, shift registers 0, synchroniser flops to idle levels (sck=CPOL, ss=1, mosi=0).
REQ-032 Output reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
REQ-033 rst asserted mid-transfer SHALL abort the word with no rx_valid; after release the block SHALL wait for a fresh ss falling edge.

Structure
REQ-034 FSM state encoding and SPI mode constants (CPOL/CPHA combinations) SHALL live in a shared package spi_pkg.
REQ-035 Synchroniser plus rise/fall edge detection SHALL be one sub-module sync_edge_det, instantiated for sck and ss.

Verification
REQ-036 Mode 0, DATA_LEN=8: load 0xA5, master sends 0x3C -> miso carries 0xA5 MSB-first, rx_data=0x3C, one rx_valid pulse.
REQ-037 Modes 1, 2, 3 each: same exchange -> identical rx_data/miso words; sampling on correct edge checked against master model.
REQ-038 Two-word frame with 0x11 loaded, 0x22 loaded after tx_ready rises -> miso 0x11 then 0x22; two rx_valid pulses.
REQ-039 No tx_load before frame -> miso 0x00, one tx_underrun pulse, rx still received correctly.
REQ-040 ss raised after 5 bits, then full frame 0x81 -> no rx_valid for partial; rx_data=0x81 after second frame.
REQ-041 rst pulsed after 3 bits -> all outputs at reset values; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared FSM state encoding and SPI mode constants for the SPI slave.
// The mode is {CPOL, CPHA}; sample_on_rise() picks which sck edge captures mosi.
package spi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic logic sample_on_rise(input logic [1:0] mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, plus rise/fall detection
// on the synchronised level. Flops reset to the line's idle level.
module sync_edge_det #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised level
  logic [2:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= {3{IDLE_LVL}};
    else     sync_reg <= {sync_reg[1:0], din};
  end

  assign lvl  = sync_reg[1];
  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/spi_slave_fd.sv
// Full-duplex SPI slave, all four modes, oversampled in the clk domain.
// One-word TX holding buffer feeds the shift register at every word boundary.
module spi_slave_fd
  import spi_pkg::*;
#(
  parameter int DATA_LEN  = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ss,
  input  logic                mosi,
  output logic                miso,
  input  logic [DATA_LEN-1:0] tx_data,
  input  logic                tx_load,
  output logic                tx_ready,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                tx_underrun,
  output logic                busy
);

  localparam logic [1:0] MODE        = {1'(CPOL), 1'(CPHA)};
  localparam logic       SAMPLE_RISE = sample_on_rise(MODE);
  localparam int         CW          = $clog2(DATA_LEN);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic [1:0] mosi_sync_reg;
  logic mosi_s;

  logic [1:0]          state_reg, state_next;
  logic [1:0]          settle_reg;
  logic                armed_reg;
  logic [CW-1:0]       bit_cnt_reg;
  logic [DATA_LEN-1:0] rx_sr_reg, rx_data_reg, tx_sr_reg, tx_buf_reg;
  logic                tx_ready_reg, rx_valid_reg, tx_underrun_reg;
  logic                fresh_reg, pend_reg, peek_full_reg;

  logic in_xfer, sample_edge, shift_edge, ss_start;
  logic boundary, load_now, deferred, commit_now, commit_full;
  logic [DATA_LEN-1:0] rx_word, tx_shifted;
  logic tx_bit;

  sync_edge_det #(.IDLE_LVL(1'(CPOL))) u_sck (
    .clk(clk), .rst(rst), .din(sck), .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_det #(.IDLE_LVL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .din(ss), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi gets the same two-flop delay as sck so the two stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_reg <= 2'b00;
    else     mosi_sync_reg <= {mosi_sync_reg[0], mosi};
  end
  assign mosi_s = mosi_sync_reg[1];

  assign in_xfer     = (state_reg == ST_XFER);
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  // A low ss seen right after reset is not a fresh falling edge; also ignore
  // a select that arrives with sck away from its idle level.
  assign ss_start    = ss_fall && armed_reg && (sck_lvl == 1'(CPOL));

  // Shift edge with the counter at 0 starts a new word, except the very first
  // leading shift edge in CPHA=1 where the word was already loaded in LOAD.
  assign boundary    = in_xfer && shift_edge && (bit_cnt_reg == '0) && !fresh_reg;
  assign load_now    = (state_reg == ST_LOAD) || boundary;
  // With CPHA=0 the boundary is the trailing edge after the last bit, which
  // also ends every frame; the buffer is only consumed once the next word's
  // first sample edge proves the word is real.
  assign deferred    = in_xfer && sample_edge && pend_reg;
  assign commit_now  = (state_reg == ST_LOAD) || (boundary && (CPHA != 0)) || deferred;
  assign commit_full = deferred ? peek_full_reg : ~tx_ready_reg;

  assign rx_word    = (MSB_FIRST != 0) ? {rx_sr_reg[DATA_LEN-2:0], mosi_s}
                                       : {mosi_s, rx_sr_reg[DATA_LEN-1:1]};
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_sr_reg[DATA_LEN-2:0], 1'b0}
                                       : {1'b0, tx_sr_reg[DATA_LEN-1:1]};
  assign tx_bit     = (MSB_FIRST != 0) ? tx_sr_reg[DATA_LEN-1] : tx_sr_reg[0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ss_start) state_next = ST_LOAD;
      ST_LOAD: state_next = ss_rise ? ST_IDLE : ST_XFER;
      ST_XFER: if (ss_rise) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      settle_reg      <= 2'b00;
      armed_reg       <= 1'b0;
      bit_cnt_reg     <= '0;
      rx_sr_reg       <= '0;
      rx_data_reg     <= '0;
      tx_sr_reg       <= '0;
      tx_buf_reg      <= '0;
      tx_ready_reg    <= 1'b1;
      rx_valid_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
      fresh_reg       <= 1'b0;
      pend_reg        <= 1'b0;
      peek_full_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      settle_reg      <= {settle_reg[0], 1'b1};
      if (settle_reg[1] && ss_lvl) armed_reg <= 1'b1;
      rx_valid_reg    <= 1'b0;
      tx_underrun_reg <= commit_now && !commit_full;

      if (commit_now && commit_full) begin
        tx_ready_reg <= 1'b1;
      end else if (tx_load && tx_ready_reg) begin
        tx_buf_reg   <= tx_data;
        tx_ready_reg <= 1'b0;
      end

      if (load_now) begin
        tx_sr_reg     <= tx_ready_reg ? '0 : tx_buf_reg;
        peek_full_reg <= ~tx_ready_reg;
      end else if (in_xfer && shift_edge && (bit_cnt_reg != '0)) begin
        tx_sr_reg <= tx_shifted;
      end

      if (boundary && (CPHA == 0)) pend_reg <= 1'b1;
      else if (deferred || !in_xfer) pend_reg <= 1'b0;

      if (state_reg == ST_LOAD) fresh_reg <= 1'b1;
      else if (in_xfer && shift_edge) fresh_reg <= 1'b0;

      // Leaving XFER drops any partial word
      if (!in_xfer || ss_rise) begin
        bit_cnt_reg <= '0;
      end else if (sample_edge) begin
        rx_sr_reg <= rx_word;
        if (bit_cnt_reg == CW'(DATA_LEN - 1)) begin
          bit_cnt_reg  <= '0;
          rx_data_reg  <= rx_word;
          rx_valid_reg <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign miso        = (state_reg == ST_IDLE) ? 1'b0 : tx_bit;
  assign tx_ready    = tx_ready_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = tx_underrun_reg;
  assign busy        = ~ss_lvl;

endmodule

// File: tb/tb_spi_slave_fd.sv
// Directed bench for spi_slave_fd: one DUT per SPI mode, each driven by a
// bit-level master task; miso words and rx results checked against constants.
module tb_spi_slave_fd;

  localparam int H = 6;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sck, ss, mosi, miso, tx_load, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];

  int checks = 0;
  int errors = 0;
  int rxv_cnt [4] = '{default: 0};
  int und_cnt [4] = '{default: 0};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave_fd #(
        .DATA_LEN(8), .CPOL(gi / 2), .CPHA(gi % 2), .MSB_FIRST(1)
      ) u_dut (
        .clk(clk), .rst(rst), .sck(sck[gi]), .ss(ss[gi]), .mosi(mosi[gi]),
        .miso(miso[gi]), .tx_data(tx_data[gi]), .tx_load(tx_load[gi]),
        .tx_ready(tx_ready[gi]), .rx_data(rx_data[gi]), .rx_valid(rx_valid[gi]),
        .tx_underrun(tx_underrun[gi]), .busy(busy[gi])
      );
    end
  endgenerate

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1)    rxv_cnt[i]++;
      if (tx_underrun[i] === 1'b1) und_cnt[i]++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [7:0] v);
    @(negedge clk);
    tx_data[m] = v;
    tx_load[m] = 1'b1;
    @(negedge clk);
    tx_load[m] = 1'b0;
  endtask

  task automatic check_reset(input int m);
    check_val("rst_miso", miso[m], 1'b0);
    check_val("rst_tx_ready", tx_ready[m], 1'b1);
    check_val("rst_rx_data", rx_data[m], 8'h00);
    check_val("rst_rx_valid", rx_valid[m], 1'b0);
    check_val("rst_tx_underrun", tx_underrun[m], 1'b0);
    check_val("rst_busy", busy[m], 1'b0);
  endtask

  // Master: shifts nbits of mo MSB-first, captures miso at each sample edge.
  task automatic spi_frame(input int m, input int nbits, input logic [15:0] mo,
                           input bit reload, input logic [7:0] reload_word,
                           input bit rst_mid, output logic [15:0] mi);
    logic cpol;
    logic cpha;
    int   k;
    cpol = 1'(m / 2);
    cpha = 1'(m % 2);
    mi   = '0;
    ss[m] = 1'b0;
    if (reload) begin
      k = 0;
      while (tx_ready[m] !== 1'b1 && k < 20) begin
        wait_clk(1);
        k++;
      end
      check_val("reload_wait_tx_ready", tx_ready[m], 1'b1);
      load_tx(m, reload_word);
    end
    wait_clk(H);
    check_val("busy", busy[m], 1'b1);
    for (int b = nbits - 1; b >= 0; b--) begin
      if (cpha == 1'b0) begin
        mosi[m] = mo[b];
        wait_clk(H);
        mi = {mi[14:0], miso[m]};
        sck[m] = ~cpol;
        wait_clk(H);
        sck[m] = cpol;
      end else begin
        sck[m]  = ~cpol;
        mosi[m] = mo[b];
        wait_clk(H);
        mi = {mi[14:0], miso[m]};
        sck[m] = cpol;
        wait_clk(H);
      end
    end
    wait_clk(H);
    if (rst_mid) begin
      rst = 1'b1;
      wait_clk(2);
      check_reset(m);
      rst = 1'b0;
      wait_clk(4);
    end
    ss[m]   = 1'b1;
    mosi[m] = 1'b0;
    wait_clk(2 * H);
    $display("frame mode=%0d bits=%0d mosi=%h miso=%h rx_data=%h", m, nbits, mo, mi, rx_data[m]);
  endtask

  initial begin
    logic [15:0] mi;
    int rv0, ud0;
    sck     = 4'b1100;
    ss      = 4'hF;
    mosi    = 4'h0;
    tx_load = 4'h0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

    wait_clk(3);
    check_reset(0);
    rst = 1'b0;
    wait_clk(5);

    // Mode 0 basic exchange
    load_tx(0, 8'hA5);
    rv0 = rxv_cnt[0];
    ud0 = und_cnt[0];
    spi_frame(0, 8, 16'h003C, 1'b0, 8'h00, 1'b0, mi);
    check_val("m0_miso", mi[7:0], 8'hA5);
    check_val("m0_rx_data", rx_data[0], 8'h3C);
    check_val("m0_rx_valid_count", rxv_cnt[0] - rv0, 1);
    check_val("m0_underrun_count", und_cnt[0] - ud0, 0);

    // Modes 1..3, same exchange
    for (int m = 1; m < 4; m++) begin
      wait_clk(5);
      load_tx(m, 8'hA5);
      rv0 = rxv_cnt[m];
      spi_frame(m, 8, 16'h003C, 1'b0, 8'h00, 1'b0, mi);
      check_val($sformatf("m%0d_miso", m), mi[7:0], 8'hA5);
      check_val($sformatf("m%0d_rx_data", m), rx_data[m], 8'h3C);
      check_val($sformatf("m%0d_rx_valid_count", m), rxv_cnt[m] - rv0, 1);
    end

    // Two-word frame, second word loaded once the buffer drains
    load_tx(0, 8'h11);
    rv0 = rxv_cnt[0];
    ud0 = und_cnt[0];
    spi_frame(0, 16, 16'h3344, 1'b1, 8'h22, 1'b0, mi);
    check_val("two_word_miso", mi, 16'h1122);
    check_val("two_word_rx_data", rx_data[0], 8'h44);
    check_val("two_word_rx_valid_count", rxv_cnt[0] - rv0, 2);
    check_val("two_word_underrun_count", und_cnt[0] - ud0, 0);
    check_val("two_word_tx_ready", tx_ready[0], 1'b1);

    // Underrun: nothing loaded
    rv0 = rxv_cnt[0];
    ud0 = und_cnt[0];
    spi_frame(0, 8, 16'h0096, 1'b0, 8'h00, 1'b0, mi);
    check_val("underrun_miso", mi[7:0], 8'h00);
    check_val("underrun_count", und_cnt[0] - ud0, 1);
    check_val("underrun_rx_data", rx_data[0], 8'h96);
    check_val("underrun_rx_valid_count", rxv_cnt[0] - rv0, 1);

    // Partial word discarded, then a full frame
    rv0 = rxv_cnt[0];
    spi_frame(0, 5, 16'h001F, 1'b0, 8'h00, 1'b0, mi);
    check_val("partial_rx_valid_count", rxv_cnt[0] - rv0, 0);
    check_val("partial_rx_data_kept", rx_data[0], 8'h96);
    rv0 = rxv_cnt[0];
    spi_frame(0, 8, 16'h0081, 1'b0, 8'h00, 1'b0, mi);
    check_val("after_partial_rx_data", rx_data[0], 8'h81);
    check_val("after_partial_rx_valid_count", rxv_cnt[0] - rv0, 1);

    // Reset mid-word, then a clean frame
    rv0 = rxv_cnt[0];
    spi_frame(0, 3, 16'h0007, 1'b0, 8'h00, 1'b1, mi);
    check_val("rst_mid_rx_valid_count", rxv_cnt[0] - rv0, 0);
    wait_clk(5);
    rv0 = rxv_cnt[0];
    spi_frame(0, 8, 16'h005A, 1'b0, 8'h00, 1'b0, mi);
    check_val("after_rst_rx_data", rx_data[0], 8'h5A);
    check_val("after_rst_rx_valid_count", rxv_cnt[0] - rv0, 1);
    check_val("after_rst_miso", mi[7:0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
